// File: rtl/uart_pkg.sv
// uart_pkg: shared UART framing levels and the transmitter state encoding.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uartState_e;
  localparam int UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL = 1'b1;
endpackage

// File: rtl/uart_rr_arb.sv
// uart_rr_arb: combinational round-robin pick; search starts at ptr and wraps upward.
module uart_rr_arb #(
  parameter int NUM_REQ = 4,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grantIdx
);
  logic           found;
  logic [IDW-1:0] cand;
  always_comb begin
    grant = '0;
    grantIdx = '0;
    found = 1'b0;
    cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NUM_REQ);
      if (enable && !found && req[cand]) begin
        grant[cand] = 1'b1;
        grantIdx = cand;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin shared 8N1 UART transmitter for NUM_REQ byte sources.
// Define UART_TX_ARB_PARITY_EN to insert an even-parity bit between d7 and stop.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CLKS_PER_BIT = 868,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 TX,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
`ifdef UART_TX_ARB_PARITY_EN
  localparam uartState_e POST_DATA = PARITY;
`else
  localparam uartState_e POST_DATA = STOP;
`endif
  uartState_e     state;
  logic [IDW-1:0] rrPtr;
  logic [IDW-1:0] winIdx;
  logic [2:0]     bitCnt;
  logic [BW-1:0]  baudCnt;
  logic [7:0]     dataReg;
  logic [7:0]     selByte;
  logic           acceptWin;
  logic           accept;
  logic           frameLevel;
  // Reset also closes the window so no ready strobe escapes while held in reset.
  assign acceptWin = rst_n && (state == IDLE || (state == STOP && baudCnt == '0));
  assign accept = |req_ready;
  assign busy = state != IDLE;
  uart_rr_arb #(.NUM_REQ(NUM_REQ)) rrArb (
    .req(req_valid),
    .ptr(rrPtr),
    .enable(acceptWin),
    .grant(req_ready),
    .grantIdx(winIdx)
  );
  always_comb begin
    selByte = '0;
    for (int i = 0; i < NUM_REQ; i++) selByte = selByte | (req_data[8*i +: 8] & {8{req_ready[i]}});
  end
  assign frameLevel = state == START ? UART_START_LEVEL :
                      state == DATA  ? dataReg[bitCnt] :
                      state == STOP  ? UART_STOP_LEVEL : UART_IDLE_LEVEL;
`ifdef UART_TX_ARB_PARITY_EN
  assign TX = state == PARITY ? ^dataReg : frameLevel;
`else
  assign TX = frameLevel;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rrPtr <= '0;
      bitCnt <= '0;
      baudCnt <= '0;
      dataReg <= '0;
      grant_id <= '0;
    end else if (accept) begin
      state <= START;
      baudCnt <= BAUD_MAX;
      bitCnt <= '0;
      dataReg <= selByte;
      grant_id <= winIdx;
      rrPtr <= IDW'((int'(winIdx) + 1) % NUM_REQ);
    end else if (state != IDLE) begin
      if (baudCnt != '0) begin
        baudCnt <= baudCnt - BW'(1);
      end else begin
        baudCnt <= BAUD_MAX;
        if (state == START) begin
          state <= DATA;
        end else if (state == DATA) begin
          bitCnt <= bitCnt + 3'd1;
          if (bitCnt == 3'(UART_DATA_BITS - 1)) state <= POST_DATA;
        end else begin
          state <= state == PARITY ? STOP : IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: randomized bench with a queue-of-line-levels reference model plus directed literal checks.
module tb_uart_tx_arb;
  localparam int NR = 4;
  localparam int CPB = 4;
`ifdef UART_TX_ARB_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic            TX;
  logic            busy;
  logic [1:0]      grant_id;
  int vectors = 0;
  int miscompares = 0;
  int cycleNo = 0;
  logic txQ[$];
  int mPtr = 0;
  int mGid = 0;
  logic [NR-1:0] mWin;

  uart_tx_arb #(.NUM_REQ(NR), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .TX(TX), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  function automatic logic [NR-1:0] rrPick(int p, logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) if (v[(p + k) % NR]) return NR'(1) << ((p + k) % NR);
    return '0;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // A frame is just the list of line levels it occupies, one entry per clock.
  task automatic pushFrame(logic [7:0] d);
    logic lv[$];
    lv.push_back(1'b0);
    for (int b = 0; b < 8; b++) lv.push_back(d[b]);
`ifdef UART_TX_ARB_PARITY_EN
    lv.push_back(^d);
`endif
    lv.push_back(1'b1);
    foreach (lv[i]) repeat (CPB) txQ.push_back(lv[i]);
  endtask

  initial forever begin
    @(posedge clk);
    cycleNo++;
  end

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      txQ.delete();
      mPtr = 0;
      mGid = 0;
    end else begin
      mWin = txQ.size() <= 1 ? rrPick(mPtr, req_valid) : '0;
      if (txQ.size() != 0) void'(txQ.pop_front());
      for (int i = 0; i < NR; i++) if (mWin[i]) begin
        pushFrame(req_data[8*i +: 8]);
        mPtr = (i + 1) % NR;
        mGid = i;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("ready", req_ready, (rst_n && txQ.size() <= 1) ? rrPick(mPtr, req_valid) : '0);
    chk("tx", TX, txQ.size() != 0 ? txQ[0] : 1'b1);
    chk("busy", busy, txQ.size() != 0);
    chk("grant_id", grant_id, mGid);
  end

  task automatic waitGrant(output int idx, output int t);
    idx = -1;
    t = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int j = 0; j < NR; j++) if (req_ready[j]) idx = j;
        t = cycleNo;
        return;
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL grant_timeout: got no ready, want a grant at t=%0t", $time);
  endtask

  task automatic waitIdle();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL idle_timeout: got busy=1, want busy=0 at t=%0t", $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish (miscompares %0d)", miscompares);
    $fatal(1);
  end

  initial begin
    int gi[5];
    int gt[5];
    int rrExp[5] = '{0, 1, 2, 3, 0};
    int idx, t, bsum, rsum, r3;
    logic txs[64];
    logic [NR-1:0] r;
    logic [NR-1:0] vld;
`ifdef UART_TX_ARB_PARITY_EN
    int lvl[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
    int lvl[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
`endif
    req_valid = 4'hF;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    #12;
    chk("rst_tx", TX, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_gid", grant_id, 0);
    tick();
    rst_n = 1'b1;
    for (int g = 0; g < 5; g++) waitGrant(gi[g], gt[g]);
    tick();
    req_valid = '0;
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("rr_order%0d", g), gi[g], rrExp[g]);
      if (g > 0) chk($sformatf("rr_gap%0d", g), gt[g] - gt[g-1], FRAME);
    end
    waitIdle();
    tick();
    req_valid = 4'b0010;
    waitGrant(idx, t);
    chk("fair_first", idx, 1);
    tick();
    req_valid = '0;
    waitIdle();
    tick();
    req_valid = 4'b0011;
    waitGrant(idx, t);
    chk("fair_wrap", idx, 0);
    tick();
    req_valid = '0;
    waitIdle();
    tick();
    req_data[23:16] = 8'hA5;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("sb_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    bsum = 0;
    rsum = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      txs[k] = TX;
      bsum += int'(busy);
      rsum += int'(req_ready != '0);
    end
    for (int k = 0; k < FRAME; k++) chk($sformatf("sb_tx%0d", k), txs[k], lvl[k / CPB]);
    chk("sb_busy_cycles", bsum, FRAME);
    chk("sb_ready_after", rsum, 0);
    chk("sb_gid", grant_id, 2);
    @(negedge clk);
    chk("sb_end_busy", busy, 0);
    chk("sb_end_tx", TX, 1);
    tick();
    req_data[7:0] = 8'h3C;
    req_valid = 4'b0001;
    waitGrant(idx, t);
    tick();
    req_valid = '0;
    repeat (12) @(posedge clk);
    #1 req_valid = 4'b1000;
    repeat (2) @(posedge clk);
    #1 req_valid = '0;
    r3 = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      r3 += int'(req_ready[3]);
    end
    chk("wd_nogrant", r3, 0);
    chk("wd_tx", TX, 1);
    chk("wd_busy", busy, 0);
    tick();
    req_data[23:16] = 8'hFF;
    req_valid = 4'b0100;
    waitGrant(idx, t);
    tick();
    req_valid = '0;
    repeat (15) @(posedge clk);
    #3;
    req_valid = 4'b1001;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", TX, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_gid", grant_id, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    waitGrant(idx, t);
    chk("post_rst_grant", idx, 0);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("post_rst_start", TX, 0);
    waitIdle();
    vld = '0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      r = req_ready;
      tick();
      for (int i = 0; i < NR; i++) begin
        if (vld[i]) begin
          if (r[i]) begin
            vld[i] = 1'($urandom_range(0, 1));
            req_data[8*i +: 8] = 8'($urandom);
          end else if ($urandom_range(0, 19) == 0) begin
            vld[i] = 1'b0;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          vld[i] = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
        end
      end
      req_valid = vld;
    end
    req_valid = '0;
    waitIdle();
`ifdef UART_TX_ARB_PARITY_EN
    tick();
    req_data[7:0] = 8'h07;
    req_valid = 4'b0001;
    waitGrant(idx, t);
    tick();
    req_valid = '0;
    bsum = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      txs[k] = TX;
      bsum += int'(busy);
    end
    chk("par_d7", txs[35], 0);
    chk("par_bit", txs[36], 1);
    chk("par_stop", txs[40], 1);
    chk("par_cycles", bsum, 44);
    waitIdle();
`endif
    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Shares one serial UART transmit line between NUM_REQ on-chip requesters.
- Each requester offers bytes on a valid/ready interface. The block grants requesters round-robin, then serialises the granted byte as 8N1, LSB first, at the configured bit time.
- Sits between firmware/debug byte sources and the board TX pin. The bench pairs it with the existing serial receive model on TX.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- CLKS_PER_BIT, 868: clk cycles per bit (100 MHz / 115200); must be ≥ 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester byte-valid.
- req_data  input  8*NUM_REQ  byte for requester i on bits [8i+7:8i].
- req_ready  output  NUM_REQ  one-hot accept strobe.
- TX  output  1  serial line; idle high.
- busy  output  1  high while a frame is in flight.
- grant_id  output  clog2(NUM_REQ)  index of the requester whose frame is in flight.

Behaviour:
- Reset values (asynchronous on rst_n low, including mid-frame):
  - TX=1, busy=0, req_ready=0, grant_id=0.
  - State=IDLE, round-robin pointer=0, bit counter=0, baud counter=0.
  - Any partial frame is abandoned, never resumed.
- State machine:
  - IDLE → START on accept.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → STOP after 8 bit periods.
  - STOP → IDLE, or STOP → START on a back-to-back accept.
- Accept window: IDLE, or the final cycle of STOP.
- Arbitration:
  - Search starts at the pointer and proceeds upward with wraparound; the first requester with req_valid=1 wins.
  - req_ready[winner] is combinational and high for exactly that one cycle; all other ready bits stay 0.
  - On accept, the byte is latched, grant_id is registered to the winner, and the pointer becomes (winner+1) mod NUM_REQ.
- Requester rules: hold valid and data stable until ready. Deasserting valid before ready is legal and simply withdraws the request.
- Latency: accept at clock edge N drives TX=0 (start bit) from edge N through N+CLKS_PER_BIT.
- Frame contents: start(0), d0..d7, stop(1). Each bit lasts exactly CLKS_PER_BIT cycles.
- Back-to-back throughput: exactly 10*CLKS_PER_BIT cycles per frame, with no idle gap.
- busy: 1 from the edge after accept through the end of STOP. It stays continuously high across back-to-back frames.
- Baud counter counts CLKS_PER_BIT-1 down to 0; the bit advances when it reaches 0. The bit counter is 3 bits and wraps 7→0 on exit to STOP.
- req_valid changes mid-frame have no effect on the frame; they are sampled only in the accept window.
- With all requesters valid continuously, grants rotate 0,1,2,…,NUM_REQ-1,0.

Optional Feature:
- Macro UART_TX_ARB_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of d0..d7) is inserted between d7 and stop; state PARITY sits between DATA and STOP.
  - Frame period becomes 11*CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic; 8N1 framing exactly as above.

Decomposition:
- Package uart_pkg:
  - State enum: IDLE, START, DATA, PARITY, STOP.
  - UART_DATA_BITS=8, UART_IDLE_LEVEL=1'b1, UART_START_LEVEL=1'b0, UART_STOP_LEVEL=1'b1.
- Sub-module uart_rr_arb (NUM_REQ):
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and grant index.
  - Purely combinational; the pointer register lives in the parent.

Test Plan (CLKS_PER_BIT=4, NUM_REQ=4):
- Single byte: req_valid[2]=1, data 0xA5, in IDLE.
  - req_ready[2] pulses 1 cycle.
  - TX=0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1; busy high 40 cycles; grant_id=2.
- Round-robin: all four valid continuously, bytes 0x10..0x13.
  - Grant order 0,1,2,3,0; frames contiguous at 40-cycle spacing; busy never drops.
- Pointer fairness: requester 1 sent last; now req_valid[0] and [1] both 1.
  - Requester 0 is next granted (search starts at 2, wraps to 0).
- Reset mid-frame: rst_n=0 at cycle 15 of a frame sending 0xFF.
  - TX=1, busy=0, req_ready=0 immediately without a clock.
  - After release, the next grant starts at requester 0 with a fresh start bit.
- Withdrawn request: req_valid[3] pulses high only during a DATA bit period.
  - No grant to requester 3; TX stays 1 after STOP.
- Parity (UART_TX_ARB_PARITY_EN defined): byte 0x07.
  - Parity bit = 1; frame 44 cycles; stop follows parity.
